// File: rtl/ab_pkg.sv
// Shared encoding for the address-bus op word. The control block builds
// ab_op from these same constants, so both sides stay in lock-step.
package ab_pkg;

    // Bit positions inside the 12-bit ab_op word
    localparam int OP_PC_INC   = 11;
    localparam int OP_PC_LD    = 10;
    localparam int OP_AHL_LD   = 9;
    localparam int OP_ABH_HI   = 8;
    localparam int OP_ABH_LO   = 5;
    localparam int OP_ABLS_HI  = 4;
    localparam int OP_ABLS_LO  = 3;
    localparam int OP_ABLOP_HI = 2;
    localparam int OP_ABLOP_LO = 1;
    localparam int OP_CI       = 0;

    // High-byte sources
    localparam logic [3:0] ABH_ZP  = 4'b0000;  // zero page, carry dropped
    localparam logic [3:0] ABH_STK = 4'b0001;  // stack page
    localparam logic [3:0] ABH_VEC = 4'b0011;  // vector page
    localparam logic [3:0] ABH_INC = 4'b0110;  // AB high + carry
    localparam logic [3:0] ABH_DEC = 4'b0111;  // AB high - 1 + carry (backward branch)
    localparam logic [3:0] ABH_PC  = 4'b1010;  // saved PC high
    localparam logic [3:0] ABH_DB  = 4'b1110;  // data bus + carry (absolute high)

    // Low-byte operations
    localparam logic [1:0] ABL_REG = 2'b00;    // REG + ci
    localparam logic [1:0] ABL_IDX = 2'b01;    // (DB or AHL) + REG + ci
    localparam logic [1:0] ABL_PC  = 2'b10;    // saved PC low
    localparam logic [1:0] ABL_AB  = 2'b11;    // AB low + (branch offset) + ci

    typedef struct packed {
        logic       pc_inc;
        logic       pc_ld;
        logic       ahl_ld;
        logic [3:0] abh_op;
        logic [1:0] abl_sel;
        logic [1:0] abl_op;
        logic       ci;
    } ab_op_t;

    // Split the raw op word into named fields
    function automatic ab_op_t decode_op(input logic [11:0] w);
        ab_op_t o;
        o.pc_inc  = w[OP_PC_INC];
        o.pc_ld   = w[OP_PC_LD];
        o.ahl_ld  = w[OP_AHL_LD];
        o.abh_op  = w[OP_ABH_HI:OP_ABH_LO];
        o.abl_sel = w[OP_ABLS_HI:OP_ABLS_LO];
        o.abl_op  = w[OP_ABLOP_HI:OP_ABLOP_LO];
        o.ci      = w[OP_CI];
        return o;
    endfunction

endpackage

// File: rtl/ab_gen_if.sv
// Address-bus interface between the control block (master) and ab_gen (slave).
interface ab_gen_if;
    logic [11:0] ab_op;
    logic        cond;
    logic [7:0]  DB;
    logic [7:0]  REG;
    logic [15:0] AB;
    logic [15:0] PC;

    modport master (output ab_op, cond, DB, REG, input AB, PC);
    modport slave  (input ab_op, cond, DB, REG, output AB, PC);
endinterface

// File: rtl/ab_low.sv
// Low address byte: source mux feeding an 8-bit adder with carry in/out.
// Purely combinational; the carry out feeds the high-byte logic.
module ab_low
    import ab_pkg::*;
(
    input  logic [1:0] abl_op,
    input  logic [1:0] abl_sel,
    input  logic       ci,
    input  logic       cond,
    input  logic [7:0] db,
    input  logic [7:0] reg_val,
    input  logic [7:0] ahl,
    input  logic [7:0] ab_lo,
    input  logic [7:0] pc_lo,
    output logic [7:0] abl,
    output logic       co
);
    logic [7:0] base;
    logic [7:0] addend;
    logic       cin;
    logic [8:0] sum;

    // Select adder operands; the PC path passes straight through with no carry
    always_comb begin
        base   = 8'h00;
        addend = 8'h00;
        cin    = 1'b0;
        case (abl_op)
            ABL_REG: begin
                base = reg_val;
                cin  = ci;
            end
            ABL_IDX: begin
                base   = abl_sel[0] ? db : ahl;
                addend = reg_val;
                cin    = ci;
            end
            ABL_PC: begin
                base = pc_lo;
            end
            ABL_AB: begin
                base   = ab_lo;
                addend = (abl_sel == 2'b11 && cond) ? db : 8'h00;
                cin    = ci;
            end
            default: ;
        endcase
    end

    assign sum = {1'b0, base} + {1'b0, addend} + {8'd0, cin};
    assign abl = sum[7:0];
    assign co  = sum[8];

endmodule

// File: rtl/ab_gen.sv
// 65C02 address bus generator: registered AB, PC save register and the
// AHL data-bus hold register. All sources are the values before the edge.
module ab_gen
    import ab_pkg::*;
#(
    parameter logic [15:0] RESET_AB = 16'h0000,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     rdy,
    ab_gen_if.slave  bus
);
    ab_op_t      op;
    logic [15:0] ab_q;
    logic [15:0] pc_q;
    logic [7:0]  ahl_q;
    logic [7:0]  abl;
    logic        co;
    logic [7:0]  abh_nxt;
    logic        abh_vld;

    assign op     = decode_op(bus.ab_op);
    assign bus.AB = ab_q;
    assign bus.PC = pc_q;

    ab_low u_low (
        .abl_op  (op.abl_op),
        .abl_sel (op.abl_sel),
        .ci      (op.ci),
        .cond    (bus.cond),
        .db      (bus.DB),
        .reg_val (bus.REG),
        .ahl     (ahl_q),
        .ab_lo   (ab_q[7:0]),
        .pc_lo   (pc_q[7:0]),
        .abl     (abl),
        .co      (co)
    );

    // High-byte mux; an unknown code freezes the whole address bus
    always_comb begin
        abh_nxt = ab_q[15:8];
        abh_vld = 1'b1;
        case (op.abh_op)
            ABH_ZP:  abh_nxt = 8'h00;
            ABH_STK: abh_nxt = 8'h01;
            ABH_VEC: abh_nxt = 8'hFF;
            ABH_INC: abh_nxt = ab_q[15:8] + {7'd0, co};
            ABH_DEC: abh_nxt = ab_q[15:8] + 8'hFF + {7'd0, co};
            ABH_PC:  abh_nxt = pc_q[15:8];
            ABH_DB:  abh_nxt = bus.DB + {7'd0, co};
            default: abh_vld = 1'b0;
        endcase
    end

    // State update; PC captures the AB that was on the bus before this edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            ab_q  <= RESET_AB;
            pc_q  <= RESET_PC;
            ahl_q <= 8'h00;
        end else if (rdy) begin
            if (op.pc_ld)  pc_q  <= ab_q + {15'd0, op.pc_inc};
            if (op.ahl_ld) ahl_q <= bus.DB;
            if (abh_vld)   ab_q  <= {abh_nxt, abl};
        end
    end

endmodule

// File: tb/tb_ab_gen.sv
// Bench for ab_gen: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against an arithmetic model.
module tb_ab_gen;
    logic clk = 1'b0;
    logic reset;
    logic rdy;

    ab_gen_if bus ();

    ab_gen #(.RESET_AB(16'h0000), .RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .rdy   (rdy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference state, kept as plain integers
    int m_ab, m_pc, m_ahl;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %04h expected %04h", name, act, exp);
        end
    endtask

    // Next state from the architectural rules: low sum carries into the
    // high byte via ordinary 16-bit arithmetic instead of a separate carry
    task automatic model_edge(input logic rst_n, input logic r, input logic [11:0] op,
                              input logic [7:0] db, input logic [7:0] rg, input logic c);
        int lo, hi, nab, ci, sel, ablop, abh;
        bit hold;
        if (!rst_n) begin
            m_ab = 0; m_pc = 0; m_ahl = 0;
            return;
        end
        if (!r) return;
        ci    = int'(op[0]);
        ablop = int'(op[2:1]);
        sel   = int'(op[4:3]);
        abh   = int'(op[8:5]);
        case (ablop)
            0: lo = int'(rg) + ci;
            1: lo = ((sel % 2) == 1 ? int'(db) : m_ahl) + int'(rg) + ci;
            2: lo = m_pc % 256;
            default: lo = (m_ab % 256) + ((sel == 3 && c) ? int'(db) : 0) + ci;
        endcase
        hi = m_ab / 256;
        hold = 1'b0;
        nab = m_ab;
        case (abh)
            0:  nab = lo % 256;
            1:  nab = 256 + lo % 256;
            3:  nab = 16'hFF00 + lo % 256;
            6:  nab = (hi * 256 + lo) % 65536;
            7:  nab = (hi * 256 + lo - 256 + 65536) % 65536;
            10: nab = (m_pc / 256) * 256 + lo % 256;
            14: nab = (int'(db) * 256 + lo) % 65536;
            default: hold = 1'b1;
        endcase
        if (op[10]) m_pc = (m_ab + int'(op[11])) % 65536;
        if (op[9])  m_ahl = int'(db);
        if (!hold)  m_ab = nab;
    endtask

    // One clock: drive on falling edge, update model at rising edge, compare after
    task automatic step(input logic rst_n, input logic r, input logic [11:0] op,
                        input logic [7:0] db, input logic [7:0] rg, input logic c);
        @(negedge clk);
        reset      = rst_n;
        rdy        = r;
        bus.ab_op  = op;
        bus.DB     = db;
        bus.REG    = rg;
        bus.cond   = c;
        @(posedge clk);
        model_edge(rst_n, r, op, db, rg, c);
        #1;
        chk("model_AB", int'(bus.AB), m_ab);
        chk("model_PC", int'(bus.PC), m_pc);
    endtask

    task automatic set_ab_10f0();
        // ABL = REG (F0), ABH = DB (10)
        step(1'b1, 1'b1, 12'b0_0_0_1110_00_00_0, 8'h10, 8'hF0, 1'b0);
        chk("setup_AB", int'(bus.AB), 16'h10F0);
    endtask

    localparam logic [11:0] MODE_0100 = 12'b011_0110_00_11_1;

    initial begin
        logic [3:0] codes [8];
        codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0011; codes[3] = 4'b0110;
        codes[4] = 4'b0111; codes[5] = 4'b1010; codes[6] = 4'b1110; codes[7] = 4'b1111;

        reset = 1'b0; rdy = 1'b1;
        bus.ab_op = '0; bus.DB = '0; bus.REG = '0; bus.cond = 1'b0;

        // Reset held with random ops
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'(i), 12'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        chk("reset_AB", int'(bus.AB), 16'h0000);
        chk("reset_PC", int'(bus.PC), 16'h0000);

        step(1'b1, 1'b1, MODE_0100, 8'h00, 8'h00, 1'b0);
        chk("inc_AB", int'(bus.AB), 16'h0001);
        chk("inc_PC", int'(bus.PC), 16'h0000);

        // Absolute,X with page cross
        step(1'b1, 1'b1, 12'b0_0_1_1111_00_11_0, 8'hF0, 8'h00, 1'b0);
        chk("ahl_hold_AB", int'(bus.AB), 16'h0001);
        step(1'b1, 1'b1, 12'b1_1_0_1110_00_01_0, 8'h12, 8'h20, 1'b0);
        chk("absx_AB", int'(bus.AB), 16'h1310);
        chk("absx_PC", int'(bus.PC), 16'h0002);

        // Zero-page index wraps inside page 0
        step(1'b1, 1'b1, 12'b0_0_0_0000_01_01_0, 8'hF0, 8'h20, 1'b0);
        chk("zp_wrap_AB", int'(bus.AB), 16'h0010);

        // Branches
        set_ab_10f0();
        step(1'b1, 1'b1, 12'b0_0_0_0110_11_11_1, 8'hFE, 8'h00, 1'b0);
        chk("br_nt_AB", int'(bus.AB), 16'h10F1);
        set_ab_10f0();
        step(1'b1, 1'b1, 12'b0_0_0_0111_11_11_1, 8'hFE, 8'h00, 1'b1);
        chk("br_back_AB", int'(bus.AB), 16'h10EF);
        set_ab_10f0();
        step(1'b1, 1'b1, 12'b0_0_0_0110_11_11_1, 8'h20, 8'h00, 1'b1);
        chk("br_fwd_AB", int'(bus.AB), 16'h1111);

        // Stack and vector pages
        step(1'b1, 1'b1, 12'b0_0_0_0001_00_00_1, 8'h00, 8'hFF, 1'b0);
        chk("stack_AB", int'(bus.AB), 16'h0100);
        step(1'b1, 1'b1, 12'b0_0_0_0011_00_00_1, 8'h00, 8'hFE, 1'b0);
        chk("vector_AB", int'(bus.AB), 16'hFFFF);

        // rdy low freezes everything
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, MODE_0100, 8'(8'h30 + i), 8'h00, 1'b0);
        chk("stall_AB", int'(bus.AB), 16'hFFFF);
        chk("stall_PC", int'(bus.PC), 16'h0002);
        step(1'b1, 1'b1, MODE_0100, 8'h55, 8'h00, 1'b0);
        chk("resume_AB", int'(bus.AB), 16'h0000);
        chk("resume_PC", int'(bus.PC), 16'hFFFF);

        // Randomized run; high-byte codes biased toward the defined ones
        for (int i = 0; i < 2000; i++) begin
            logic [11:0] op;
            logic [3:0]  abh;
            abh = ($urandom_range(0, 9) == 0) ? 4'($urandom) : codes[$urandom_range(0, 7)];
            op  = {3'($urandom), abh, 5'($urandom)};
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) != 0), op,
                 8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
